// File: rtl/noise_fifo_pkg.sv
// noise_fifo_pkg
//   Shared defaults and FSM encoding for the noise sample FIFO.
//   DATA_WIDTH_DEF  : default sample width
//   DEPTH_DEF       : default word capacity (power of two, >= 4)
//   PRIME_LEVEL_DEF : default fill level that primes the FIFO
//   state_t         : fill-tracking FSM encoding
package noise_fifo_pkg;

   localparam int DATA_WIDTH_DEF  = 12;
   localparam int DEPTH_DEF       = 32;
   localparam int PRIME_LEVEL_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_FILL   = 2'd1,
      S_PRIMED = 2'd2
   } state_t;

endpackage

// File: rtl/noise_fifo_mem.sv
// fifo_mem
//   Simple dual-port sample storage: synchronous write, registered read,
//   no reset on either the array or the read register.
//   clk     : clock
//   wr_en   : write strobe
//   wr_addr : write address
//   wr_data : write data
//   rd_en   : read strobe; rd_data holds when low
//   rd_addr : read address
//   rd_data : registered read data
module fifo_mem
   import noise_fifo_pkg::*;
#(
   parameter int DATA_WIDTH = DATA_WIDTH_DEF,
   parameter int DEPTH      = DEPTH_DEF
) (
   input  logic                     clk,
   input  logic                     wr_en,
   input  logic [$clog2(DEPTH)-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0]    wr_data,
   input  logic                     rd_en,
   input  logic [$clog2(DEPTH)-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0]    rd_data
);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [DATA_WIDTH-1:0] rd_data_q;

   // With both addresses equal (full FIFO, simultaneous read/write) the read
   // register captures the old word, which is the head being read out.
   always_ff @(posedge clk) begin
      if (wr_en) mem_q[wr_addr] <= wr_data;
      if (rd_en) rd_data_q <= mem_q[rd_addr];
   end

   assign rd_data = rd_data_q;

endmodule

// File: rtl/noise_fifo.sv
// noise_fifo
//   Buffers noise generator samples for the output register and tracks
//   whether enough samples are stored (PRIMED).
//   Optional macro NOISE_FIFO_ERR_FLAGS_EN builds the sticky OVERFLOW /
//   UNDERFLOW registers; without it both outputs are tied low.
//   CLK        : clock
//   RESET      : asynchronous active-high reset
//   WR_EN      : write strobe, WR_DATA : sample in
//   FIFO_REQ   : read request
//   CLEAR      : synchronous flush, overrides WR_EN / FIFO_REQ
//   DATA_OUT   : registered read data, DATA_VALID : updated this cycle
//   FULL / EMPTY / PRIMED / LEVEL : status
//   OVERFLOW / UNDERFLOW : sticky error flags
//
//   state    | meaning
//   S_IDLE   | nothing written since reset/clear/drain
//   S_FILL   | accepting samples, level below PRIME_LEVEL
//   S_PRIMED | enough samples stored for the consumer
module noise_fifo
   import noise_fifo_pkg::*;
#(
   parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
   parameter int DEPTH       = DEPTH_DEF,
   parameter int PRIME_LEVEL = PRIME_LEVEL_DEF
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     WR_EN,
   input  logic [DATA_WIDTH-1:0]    WR_DATA,
   input  logic                     FIFO_REQ,
   input  logic                     CLEAR,
   output logic [DATA_WIDTH-1:0]    DATA_OUT,
   output logic                     DATA_VALID,
   output logic                     FULL,
   output logic                     EMPTY,
   output logic                     PRIMED,
   output logic [$clog2(DEPTH):0]   LEVEL,
   output logic                     OVERFLOW,
   output logic                     UNDERFLOW
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE   = (AW+1)'(1);
   localparam logic [AW:0] PRIME_LVL = (AW+1)'(PRIME_LEVEL);

   logic [AW:0] wr_ptr_q, wr_ptr_d;
   logic [AW:0] rd_ptr_q, rd_ptr_d;
   logic [AW:0] level_q, level_d;
   logic        valid_q, valid_d;
   logic        seen_q, seen_d;
   state_t      state_q, state_d;

   logic                  empty, full, rd_fire, wr_fire;
   logic [DATA_WIDTH-1:0] mem_rd_data;

   assign empty = (wr_ptr_q == rd_ptr_q);
   assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

   // A full FIFO still accepts a write when a read frees the slot this cycle.
   assign rd_fire = FIFO_REQ && !empty && !CLEAR;
   assign wr_fire = WR_EN && (!full || rd_fire) && !CLEAR;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (CLEAR) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
      end else begin
         if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
         if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      level_d = wr_ptr_d - rd_ptr_d;
      valid_d = rd_fire;
      seen_d  = seen_q || rd_fire;
   end

   always_comb begin
      state_d = state_q;
      if (CLEAR) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (wr_fire) state_d = S_FILL;
            S_FILL:   if (level_q >= PRIME_LVL) state_d = S_PRIMED;
            S_PRIMED: if (empty && !wr_fire) state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
         valid_q  <= 1'b0;
         seen_q   <= 1'b0;
         state_q  <= S_IDLE;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         level_q  <= level_d;
         valid_q  <= valid_d;
         seen_q   <= seen_d;
         state_q  <= state_d;
      end
   end

   fifo_mem #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH)
   ) u_mem (
      .clk     (CLK),
      .wr_en   (wr_fire),
      .wr_addr (wr_ptr_q[AW-1:0]),
      .wr_data (WR_DATA),
      .rd_en   (rd_fire),
      .rd_addr (rd_ptr_q[AW-1:0]),
      .rd_data (mem_rd_data)
   );

   // The storage read register has no reset; seen_q masks it to zero until
   // the first read after reset, so DATA_OUT clears asynchronously with RESET.
   // CLEAR leaves seen_q alone so DATA_OUT holds across a flush.
   assign DATA_OUT   = seen_q ? mem_rd_data : '0;
   assign DATA_VALID = valid_q;
   assign FULL       = full;
   assign EMPTY      = empty;
   assign PRIMED     = (state_q == S_PRIMED);
   assign LEVEL      = level_q;

`ifdef NOISE_FIFO_ERR_FLAGS_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   always_comb begin
      ovf_d = ovf_q;
      unf_d = unf_q;
      if (CLEAR) begin
         ovf_d = 1'b0;
         unf_d = 1'b0;
      end else begin
         if (WR_EN && full && !rd_fire) ovf_d = 1'b1;
         if (FIFO_REQ && empty)         unf_d = 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign OVERFLOW  = ovf_q;
   assign UNDERFLOW = unf_q;
`else
   assign OVERFLOW  = 1'b0;
   assign UNDERFLOW = 1'b0;
`endif

endmodule

// File: tb/tb_noise_fifo.sv
// tb_noise_fifo
//   Randomized and directed stimulus against a queue-based reference model;
//   read data is scoreboarded through exp_q and checked by a negedge monitor.
module tb_noise_fifo;

   localparam int DW    = 12;
   localparam int DEPTH = 32;
   localparam int PRIME = 8;
`ifdef NOISE_FIFO_ERR_FLAGS_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RESET = 1'b0;
   logic          WR_EN = 1'b0;
   logic [DW-1:0] WR_DATA = '0;
   logic          FIFO_REQ = 1'b0;
   logic          CLEAR = 1'b0;
   logic [DW-1:0] DATA_OUT;
   logic          DATA_VALID, FULL, EMPTY, PRIMED, OVERFLOW, UNDERFLOW;
   logic [5:0]    LEVEL;

   noise_fifo #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .PRIME_LEVEL(PRIME)) dut (
      .CLK        (CLK),
      .RESET      (RESET),
      .WR_EN      (WR_EN),
      .WR_DATA    (WR_DATA),
      .FIFO_REQ   (FIFO_REQ),
      .CLEAR      (CLEAR),
      .DATA_OUT   (DATA_OUT),
      .DATA_VALID (DATA_VALID),
      .FULL       (FULL),
      .EMPTY      (EMPTY),
      .PRIMED     (PRIMED),
      .LEVEL      (LEVEL),
      .OVERFLOW   (OVERFLOW),
      .UNDERFLOW  (UNDERFLOW)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   // reference model: stored words, scoreboard of expected reads, flags
   logic [DW-1:0] mq[$];
   logic [DW-1:0] exp_q[$];
   int            phase;      // 0 idle, 1 filling, 2 primed
   bit            m_ovf, m_unf, m_valid;
   logic [DW-1:0] m_last;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   always @(posedge CLK or posedge RESET) begin : model
      int pre;
      bit rd, wr;
      if (RESET) begin
         mq.delete();
         exp_q.delete();
         phase   = 0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_valid = 1'b0;
         m_last  = '0;
      end else if (CLEAR) begin
         mq.delete();
         phase   = 0;
         m_ovf   = 1'b0;
         m_unf   = 1'b0;
         m_valid = 1'b0;
      end else begin
         pre = mq.size();
         rd  = FIFO_REQ && (pre != 0);
         wr  = WR_EN && ((pre != DEPTH) || rd);
         if (phase == 0 && wr) phase = 1;
         else if (phase == 1 && pre >= PRIME) phase = 2;
         else if (phase == 2 && pre == 0 && !wr) phase = 0;
         if (FIFO_REQ && pre == 0) m_unf = 1'b1;
         if (WR_EN && pre == DEPTH && !rd) m_ovf = 1'b1;
         if (rd) begin
            m_last = mq.pop_front();
            exp_q.push_back(m_last);
         end
         if (wr) mq.push_back(WR_DATA);
         m_valid = rd;
      end
   end

   always @(negedge CLK) begin : monitor
      logic [DW-1:0] d;
      chk("level",      int'(LEVEL),      mq.size());
      chk("full",       int'(FULL),       int'(mq.size() == DEPTH));
      chk("empty",      int'(EMPTY),      int'(mq.size() == 0));
      chk("primed",     int'(PRIMED),     int'(phase == 2));
      chk("overflow",   int'(OVERFLOW),   int'(ERR_EN && m_ovf));
      chk("underflow",  int'(UNDERFLOW),  int'(ERR_EN && m_unf));
      chk("data_valid", int'(DATA_VALID), int'(m_valid));
      chk("data_out",   int'(DATA_OUT),   int'(m_last));
      if (DATA_VALID) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_spurious actual=valid_with_no_pending_read expected=no_valid t=%0t", $time);
         end else begin
            d = exp_q.pop_front();
            chk("sb_data", int'(DATA_OUT), int'(d));
         end
      end
   end

   task automatic cyc(input bit w, input logic [DW-1:0] d, input bit r, input bit c);
      WR_EN    = w;
      WR_DATA  = d;
      FIFO_REQ = r;
      CLEAR    = c;
      @(posedge CLK);
      #1;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_level"},  int'(LEVEL),      0);
      chk({tag, "_empty"},  int'(EMPTY),      1);
      chk({tag, "_full"},   int'(FULL),       0);
      chk({tag, "_primed"}, int'(PRIMED),     0);
      chk({tag, "_dout"},   int'(DATA_OUT),   0);
      chk({tag, "_valid"},  int'(DATA_VALID), 0);
      chk({tag, "_ovf"},    int'(OVERFLOW),   0);
      chk({tag, "_unf"},    int'(UNDERFLOW),  0);
   endtask

   initial begin
      #1 RESET = 1'b1;
      #1 chk_reset_vals("rst");
      #10 RESET = 1'b0;
      @(posedge CLK);
      #1;

      // eight words in, prime, then read back in order
      for (int i = 1; i <= 8; i++) cyc(1'b1, DW'(i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

      // read while empty: sticky underflow until CLEAR
      repeat (3) cyc(1'b0, '0, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);
      cyc(1'b0, '0, 1'b0, 1'b0);

      // 33 writes into 32 slots
      for (int i = 0; i < 33; i++) cyc(1'b1, DW'(12'h100 + i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b1);

      // full FIFO streaming through pointer wrap
      for (int i = 0; i < 32; i++) cyc(1'b1, DW'(12'h200 + i), 1'b0, 1'b0);
      for (int i = 0; i < 40; i++) cyc(1'b1, DW'($urandom), 1'b1, 1'b0);
      for (int i = 0; i < 32; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b0, '0, 1'b0, 1'b0);

      // asynchronous reset mid-stream at level 17
      for (int i = 0; i < 17; i++) cyc(1'b1, DW'(12'h300 + i), 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      cyc(1'b1, 12'h555, 1'b0, 1'b0);
      WR_EN = 1'b0;
      #2 RESET = 1'b1;
      #1 chk_reset_vals("mid_rst");
      #3 RESET = 1'b0;
      @(posedge CLK);
      #1;
      cyc(1'b1, 12'hABC, 1'b0, 1'b0);
      cyc(1'b0, '0, 1'b1, 1'b0);
      repeat (2) cyc(1'b0, '0, 1'b0, 1'b0);

      // randomized traffic: write-heavy, read-heavy, balanced
      for (int i = 0; i < 600; i++) begin
         int wp;
         wp = (i < 200) ? 75 : (i < 400) ? 25 : 50;
         cyc($urandom_range(0, 99) < wp, DW'($urandom),
             $urandom_range(0, 99) < (100 - wp), $urandom_range(0, 99) < 2);
      end

      for (int i = 0; i < 40; i++) cyc(1'b0, '0, 1'b1, 1'b0);
      repeat (3) cyc(1'b0, '0, 1'b0, 1'b0);
      chk("sb_drained", exp_q.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/noise_fifo.md
NOISE_FIFO -- requirements
Module: noise_fifo

Interface
REQ-001 Parameter DATA_WIDTH, default 12: sample width in bits.
REQ-002 Parameter DEPTH, default 32: word capacity, power of two, minimum 4.
REQ-003 Parameter PRIME_LEVEL, default 8: fill level at which PRIMED asserts, range 1..DEPTH.
REQ-004 Port CLK  in  1  sole clock; all state changes on its rising edge.
REQ-005 Port RESET  in  1  asynchronous, active-high reset.
REQ-006 Port WR_EN  in  1  write strobe from the noise generator; one word per cycle while high.
REQ-007 Port WR_DATA  in  DATA_WIDTH  sample to write.
REQ-008 Port FIFO_REQ  in  1  read request from the output register; one word per cycle while high.
REQ-009 Port CLEAR  in  1  synchronous flush.
REQ-010 Port DATA_OUT  out  DATA_WIDTH  registered read data, fed to the output register's FIFO data input.
REQ-011 Port DATA_VALID  out  1  DATA_OUT was updated this cycle.
REQ-012 Port FULL, EMPTY, PRIMED  out  1 each  status flags.
REQ-013 Port LEVEL  out  log2(DEPTH)+1  current word count.
REQ-014 Port OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.

Function
REQ-015 Pointers SHALL be log2(DEPTH)+1 bits and wrap modulo 2*DEPTH; FULL is asserted when the pointers differ only in the MSB; EMPTY when they are equal.
REQ-016 LEVEL SHALL equal wr_ptr minus rd_ptr, unsigned modulo 2*DEPTH, and be registered.
REQ-017 A read SHALL occur when FIFO_REQ=1 and EMPTY=0; DATA_OUT SHALL take the head word at the next edge, with DATA_VALID=1 for that one cycle (latency 1).
REQ-018 When FIFO_REQ=1 and EMPTY=1: no read occurs, DATA_OUT holds its value, DATA_VALID=0, and UNDERFLOW sets.
REQ-019 A write SHALL occur when WR_EN=1 and FULL=0; when WR_EN=1 and FULL=1 the word is dropped and OVERFLOW sets.
REQ-020 Simultaneous read and write: both are performed and LEVEL is unchanged; when FULL=1 the write is accepted because the read frees a slot that same cycle.
REQ-021 Simultaneous read and write while EMPTY=1: the write is performed and the read is treated as an underflow; there is no bypass path.
REQ-022 The FSM SHALL have three states: S_IDLE, S_FILL and S_PRIMED.
REQ-023 FSM transitions: S_IDLE to S_FILL on the first accepted write; S_FILL to S_PRIMED when LEVEL reaches PRIME_LEVEL or more; S_PRIMED to S_IDLE when EMPTY=1 with no write in that cycle; any state to S_IDLE on CLEAR.
REQ-024 PRIMED SHALL be 1 only in S_PRIMED.
REQ-025 CLEAR SHALL zero both pointers, LEVEL, OVERFLOW, UNDERFLOW and DATA_VALID; DATA_OUT holds; CLEAR overrides WR_EN and FIFO_REQ in the same cycle.

Reset
REQ-026 On RESET=1 and asynchronously: pointers 0, LEVEL 0, EMPTY 1, FULL 0, PRIMED 0, DATA_OUT 0, DATA_VALID 0, OVERFLOW 0, UNDERFLOW 0, FSM in S_IDLE.
REQ-027 Memory contents are not reset; a reset mid-stream discards all stored words.

Configuration
REQ-028 Macro NOISE_FIFO_ERR_FLAGS_EN defined: OVERFLOW and UNDERFLOW behave per REQ-018, REQ-019 and REQ-025.
REQ-029 Macro NOISE_FIFO_ERR_FLAGS_EN undefined: OVERFLOW and UNDERFLOW are tied to 0 and no sticky registers are built; all other behaviour is unchanged.

Structure
REQ-030 Package noise_fifo_pkg SHALL hold the DATA_WIDTH and DEPTH defaults and the FSM state encoding (S_IDLE=2'd0, S_FILL=2'd1, S_PRIMED=2'd2).
REQ-031 Storage SHALL be a sub-module fifo_mem: simple dual-port, synchronous write, registered read, no reset.

Verification
REQ-032 Write 8 words 0x001..0x008 after reset: PRIMED=1 one cycle after LEVEL=8; FIFO_REQ held for 8 cycles returns 0x001..0x008 in order, each 1 cycle after its request; EMPTY=1 at the end.
REQ-033 Write 33 words with DEPTH=32: FULL=1 after the 32nd write, the 33rd word is dropped, OVERFLOW=1, LEVEL=32.
REQ-034 FIFO_REQ=1 while empty: DATA_VALID=0, DATA_OUT unchanged, UNDERFLOW=1 until CLEAR.
REQ-035 FIFO full, WR_EN and FIFO_REQ both high for 40 cycles: LEVEL stays 32, no OVERFLOW, read order is preserved across pointer wrap.
REQ-036 RESET pulsed mid-stream at LEVEL=17: all outputs reach reset values without waiting for a clock edge; the next write/read pair returns the new word.
REQ-037 Build without NOISE_FIFO_ERR_FLAGS_EN and repeat REQ-033 and REQ-034: OVERFLOW and UNDERFLOW stay 0 and data behaviour is identical.
